fp_accum_feeder: RTL and testbench

Upstream feeder for `floating_point_accum`. It buffers incoming FP32 samples in a small FIFO and issues them one at a time to the accumulator over its `load`/`busy` handshake. It counts samples per burst and, after `BURST_LEN` additions, captures the accumulator's `sum` and `status` as a one-cycle result.

---
 rtl/fp_accum_pkg.sv | 18 +
 rtl/fp_sample_fifo.sv | 52 +++++
 rtl/fp_accum_feeder.sv | 138 +++++++++++++
 tb/tb_fp_accum_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the FP32 accumulator feeder.
package fp_accum_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } feeder_state_t;

    localparam fp32_t FP32_ONE = 32'h3f800000;

endpackage

// File: rtl/fp_sample_fifo.sv
// Sample FIFO: synchronous push/pop, pointers one bit wider than the address
// so that full and empty can be told apart without a separate counter.
module fp_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int FP_W  = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_push,
    input  logic [FP_W-1:0]        i_data,
    input  logic                   i_pop,
    output logic [FP_W-1:0]        o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [FP_W-1:0] r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // A request against a full/empty FIFO is simply ignored.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO and discards its contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fp_accum_feeder.sv
// Feeds buffered FP32 samples one at a time into floating_point_accum over
// its load/busy handshake and reports the running sum every BURST_LEN adds.
// Data is never modified: NaN/Inf patterns pass through bit-exact.
module fp_accum_feeder
    import fp_accum_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            acc_a,
    output logic                   acc_load,
    input  logic                   acc_busy,
    input  logic                   acc_status,
    input  logic [31:0]            acc_sum,
    output logic [31:0]            res_sum,
    output logic                   res_valid,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] level
);

    localparam int          LVL_W     = $clog2(DEPTH) + 1;
    localparam logic [15:0] BURST_CNT = 16'(BURST_LEN);

    feeder_state_t r_state;
    fp32_t         r_acc_a;
    fp32_t         r_res_sum;
    logic          r_acc_load;
    logic          r_res_valid;
    logic          r_res_err;
    logic          r_sticky;
    logic          r_live;
    logic [15:0]   r_cnt;

    fp32_t         w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [LVL_W-1:0] w_level;

    // Pop only from IDLE, and only once the accumulator is free.
    assign w_pop  = (r_state == IDLE) & ~w_empty & ~acc_busy;
    assign w_push = in_valid & in_ready;

    // r_live keeps in_ready low while reset is asserted.
    assign in_ready  = r_live & ~w_full;
    assign acc_a     = r_acc_a;
    assign acc_load  = r_acc_load;
    assign res_sum   = r_res_sum;
    assign res_valid = r_res_valid;
    assign res_err   = r_res_err;
    assign level     = w_level;

    fp_sample_fifo #(
        .DEPTH (DEPTH),
        .FP_W  (FP_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Goes high on the first clock after reset release to open the input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_live <= 1'b0;
        else         r_live <= 1'b1;
    end

    // Handshake FSM with burst counter, sticky error and result capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_acc_a     <= '0;
            r_acc_load  <= 1'b0;
            r_res_sum   <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_acc_a    <= w_head;
                        r_acc_load <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    // acc_load was high for exactly this one cycle.
                    r_acc_load <= 1'b0;
                    r_state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (acc_busy) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!acc_busy) begin
                        r_sticky <= r_sticky | acc_status;
                        r_cnt    <= r_cnt + 16'd1;
                        if (r_cnt + 16'd1 == BURST_CNT) begin
                            // Capture here so the result is registered while in DONE.
                            r_res_sum   <= acc_sum;
                            r_res_err   <= r_sticky | acc_status;
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    r_res_valid <= 1'b0;
                    r_cnt       <= '0;
                    r_sticky    <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_acc_load  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_feeder.sv
// Bench for fp_accum_feeder: a behavioural accumulator stands in for
// floating_point_accum; expected loads and burst results are derived from the
// pushed sample list with plain integer arithmetic.
module tb_fp_accum_feeder;

    localparam int DEPTH     = 16;
    localparam int BURST_LEN = 10;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam logic [31:0] ONE = 32'h3f800000;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   acc_a;
    logic          acc_load;
    logic          acc_busy;
    logic          acc_status;
    logic [31:0]   acc_sum;
    logic [31:0]   res_sum;
    logic          res_valid;
    logic          res_err;
    logic [LW-1:0] level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_accum_feeder #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_a      (acc_a),
        .acc_load   (acc_load),
        .acc_busy   (acc_busy),
        .acc_status (acc_status),
        .acc_sum    (acc_sum),
        .res_sum    (res_sum),
        .res_valid  (res_valid),
        .res_err    (res_err),
        .level      (level)
    );

    // Integer-valued FP32 helpers (exact for the small magnitudes used here).
    function automatic logic [31:0] fp_of_int(input int n);
        int p;
        int m;
        if (n <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (n[i]) p = i;
        m = (n << (23 - p)) & 32'h007fffff;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int int_of_fp(input logic [31:0] x);
        int e;
        logic [31:0] mant;
        if (x[30:23] == 8'h00) return 0;
        e = int'(x[30:23]) - 127;
        mant = {9'b0, 1'b1, x[22:0]};
        return int'(mant >> (23 - e));
    endfunction

    function automatic bit is_exc(input logic [31:0] x);
        return x[30:23] == 8'hff;
    endfunction

    // Behavioural accumulator: busy for a few cycles per load, then updates sum.
    logic        m_busy;
    int          m_left;
    logic [31:0] m_op;
    int          m_sum_int;
    logic        m_status;
    int          m_loads;
    int          err_idx = 0;
    bit          rand_busy = 1'b0;
    bit          force_busy = 1'b0;

    assign acc_busy   = m_busy | force_busy;
    assign acc_status = m_status;
    assign acc_sum    = fp_of_int(m_sum_int);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0; m_left <= 0; m_op <= '0;
            m_sum_int <= 0; m_status <= 1'b0; m_loads <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                if (is_exc(m_op)) m_status <= 1'b1;
                else begin
                    m_status  <= (m_loads == err_idx);
                    m_sum_int <= m_sum_int + int_of_fp(m_op);
                end
            end
        end else if (acc_load) begin
            m_op    <= acc_a;
            m_busy  <= 1'b1;
            m_left  <= rand_busy ? int'($urandom_range(1, 6)) : 4;
            m_loads <= m_loads + 1;
        end
    end

    // Monitor: record load operands, results and back-to-back load pulses.
    logic [31:0] loads_q[$];
    logic [31:0] rsum_q[$];
    bit          rerr_q[$];
    int          rat_q[$];
    int          dbl_cnt = 0;
    bit          prev_load = 1'b0;

    always @(negedge clk) begin
        if (resetn) begin
            if (acc_load) loads_q.push_back(acc_a);
            if (acc_load && prev_load) dbl_cnt <= dbl_cnt + 1;
            if (res_valid) begin
                rsum_q.push_back(res_sum);
                rerr_q.push_back(res_err);
                rat_q.push_back(loads_q.size());
            end
            prev_load <= acc_load;
        end else begin
            prev_load <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; force_busy = 1'b0; err_idx = 0; rand_busy = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at a falling edge with in_valid low.
    task automatic push(input logic [31:0] d, output bit ok);
        in_data = d; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_loads(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (loads_q.size() >= target) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_res(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (rsum_q.size() >= target) ok = 1'b1;
            else @(negedge clk);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_cmp++; if (acc_load !== 1'b0) begin n_err++; $display("FAIL rst_acc_load got %b want 0", acc_load); end
        n_cmp++; if (acc_a !== 32'h0) begin n_err++; $display("FAIL rst_acc_a got %h want 0", acc_a); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_sum !== 32'h0) begin n_err++; $display("FAIL rst_res_sum got %h want 0", res_sum); end
        n_cmp++; if (res_err !== 1'b0) begin n_err++; $display("FAIL rst_res_err got %b want 0", res_err); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_hold_in_ready got %b want 0", in_ready); end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (acc_load !== 1'b0) begin n_err++; $display("FAIL idle_acc_load got %b want 0", acc_load); end
    endtask

    task automatic test_nominal();
        int bl, br, good;
        bit ok;
        do_reset();
        bl = loads_q.size(); br = rsum_q.size(); good = 0;
        for (int i = 0; i < 10; i++) begin push(ONE, ok); good += int'(ok); end
        wait_res(br + 1, ok);
        n_cmp++; if (good !== 10) begin n_err++; $display("FAIL nom_pushes got %0d want 10", good); end
        n_cmp++; if (loads_q.size() - bl !== 10) begin n_err++; $display("FAIL nom_loads got %0d want 10", loads_q.size() - bl); end
        n_cmp++; if (rsum_q.size() - br !== 1) begin n_err++; $display("FAIL nom_results got %0d want 1", rsum_q.size() - br); end
        if (rsum_q.size() > br) begin
            n_cmp++; if (rsum_q[br] !== 32'h41200000) begin n_err++; $display("FAIL nom_sum got %h want 41200000", rsum_q[br]); end
            n_cmp++; if (rerr_q[br] !== 1'b0) begin n_err++; $display("FAIL nom_err got %b want 0", rerr_q[br]); end
        end
        for (int i = bl; i < loads_q.size(); i++) begin
            n_cmp++; if (loads_q[i] !== ONE) begin n_err++; $display("FAIL nom_acc_a[%0d] got %h want %h", i - bl, loads_q[i], ONE); end
        end
    endtask

    task automatic test_backpressure();
        int bl, br, good;
        bit ok;
        do_reset();
        bl = loads_q.size(); br = rsum_q.size(); good = 0;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin push(ONE, ok); good += int'(ok); end
        in_data = ONE; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL bp_level got %0d want 16", level); end
        n_cmp++; if (loads_q.size() !== bl) begin n_err++; $display("FAIL bp_no_load got %0d want 0", loads_q.size() - bl); end
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin push(ONE, ok); good += int'(ok); end
        wait_res(br + 2, ok);
        n_cmp++; if (good !== 20) begin n_err++; $display("FAIL bp_pushes got %0d want 20", good); end
        n_cmp++; if (loads_q.size() - bl !== 20) begin n_err++; $display("FAIL bp_loads got %0d want 20", loads_q.size() - bl); end
        n_cmp++; if (rsum_q.size() - br !== 2) begin n_err++; $display("FAIL bp_results got %0d want 2", rsum_q.size() - br); end
        if (rsum_q.size() >= br + 2) begin
            n_cmp++; if (rsum_q[br] !== 32'h41200000) begin n_err++; $display("FAIL bp_sum0 got %h want 41200000", rsum_q[br]); end
            n_cmp++; if (rsum_q[br+1] !== 32'h41a00000) begin n_err++; $display("FAIL bp_sum1 got %h want 41a00000", rsum_q[br+1]); end
        end
    endtask

    task automatic test_sticky();
        int br;
        bit ok;
        do_reset();
        br = rsum_q.size();
        err_idx = 2;
        for (int i = 0; i < 20; i++) push(ONE, ok);
        wait_res(br + 2, ok);
        n_cmp++; if (rsum_q.size() - br !== 2) begin n_err++; $display("FAIL st_results got %0d want 2", rsum_q.size() - br); end
        if (rsum_q.size() >= br + 2) begin
            n_cmp++; if (rerr_q[br] !== 1'b1) begin n_err++; $display("FAIL st_err0 got %b want 1", rerr_q[br]); end
            n_cmp++; if (rerr_q[br+1] !== 1'b0) begin n_err++; $display("FAIL st_err1 got %b want 0", rerr_q[br+1]); end
            n_cmp++; if (rsum_q[br+1] !== 32'h41a00000) begin n_err++; $display("FAIL st_sum1 got %h want 41a00000", rsum_q[br+1]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] list[$];
        logic [31:0] specials[4];
        logic [31:0] v;
        int bl, br, total;
        bit ok, e;
        specials[0] = 32'h7fc00000; specials[1] = 32'h7f800000;
        specials[2] = 32'hff800000; specials[3] = 32'h7f800001;
        do_reset();
        rand_busy = 1'b1;
        bl = loads_q.size(); br = rsum_q.size();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) v = specials[$urandom_range(0, 3)];
            else v = fp_of_int(int'($urandom_range(1, 50)));
            list.push_back(v);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(v, ok);
        end
        wait_res(br + 3, ok);
        n_cmp++; if (loads_q.size() - bl !== 30) begin n_err++; $display("FAIL rnd_loads got %0d want 30", loads_q.size() - bl); end
        for (int i = 0; i < 30 && bl + i < loads_q.size(); i++) begin
            n_cmp++; if (loads_q[bl+i] !== list[i]) begin n_err++; $display("FAIL rnd_acc_a[%0d] got %h want %h", i, loads_q[bl+i], list[i]); end
        end
        n_cmp++; if (rsum_q.size() - br !== 3) begin n_err++; $display("FAIL rnd_results got %0d want 3", rsum_q.size() - br); end
        total = 0;
        for (int b = 0; b < 3 && br + b < rsum_q.size(); b++) begin
            e = 1'b0;
            for (int j = 0; j < 10; j++) begin
                if (is_exc(list[b*10+j])) e = 1'b1;
                else total += int_of_fp(list[b*10+j]);
            end
            n_cmp++; if (rsum_q[br+b] !== fp_of_int(total)) begin n_err++; $display("FAIL rnd_sum%0d got %h want %h", b, rsum_q[br+b], fp_of_int(total)); end
            n_cmp++; if (rerr_q[br+b] !== e) begin n_err++; $display("FAIL rnd_err%0d got %b want %b", b, rerr_q[br+b], e); end
        end
    endtask

    task automatic test_reset_mid();
        int bl, br;
        bit ok;
        do_reset();
        bl = loads_q.size(); br = rsum_q.size();
        for (int i = 0; i < 10; i++) push(ONE, ok);
        wait_loads(bl + 5, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_wait5 got timeout want 5 loads"); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL mid_level got %0d want 0", level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        n_cmp++; if (acc_a !== 32'h0) begin n_err++; $display("FAIL mid_acc_a got %h want 0", acc_a); end
        n_cmp++; if (acc_load !== 1'b0) begin n_err++; $display("FAIL mid_acc_load got %b want 0", acc_load); end
        n_cmp++; if (rsum_q.size() !== br) begin n_err++; $display("FAIL mid_early_res got %0d want 0", rsum_q.size() - br); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bl = loads_q.size(); br = rsum_q.size();
        for (int i = 0; i < 10; i++) push(ONE, ok);
        wait_res(br + 1, ok);
        n_cmp++; if (rsum_q.size() - br !== 1) begin n_err++; $display("FAIL mid_results got %0d want 1", rsum_q.size() - br); end
        if (rsum_q.size() > br) begin
            n_cmp++; if (rat_q[br] - bl !== 10) begin n_err++; $display("FAIL mid_res_after got %0d want 10", rat_q[br] - bl); end
            n_cmp++; if (rsum_q[br] !== 32'h41200000) begin n_err++; $display("FAIL mid_sum got %h want 41200000", rsum_q[br]); end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] list[$];
        int bl, br, total;
        bit ok;
        do_reset();
        bl = loads_q.size(); br = rsum_q.size();
        for (int i = 0; i < 17; i++) list.push_back(fp_of_int(int'($urandom_range(1, 40))));
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(list[i], ok);
        in_data = list[16]; in_valid = 1'b1;
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL sim_full got %0d want 16", level); end
        force_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if (level !== 5'd15) begin n_err++; $display("FAIL sim_pop_level got %0d want 15", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL sim_push_level got %0d want 16", level); end
        wait_loads(bl + 17, ok);
        wait_res(br + 1, ok);
        n_cmp++; if (loads_q.size() - bl !== 17) begin n_err++; $display("FAIL sim_loads got %0d want 17", loads_q.size() - bl); end
        for (int i = 0; i < 17 && bl + i < loads_q.size(); i++) begin
            n_cmp++; if (loads_q[bl+i] !== list[i]) begin n_err++; $display("FAIL sim_acc_a[%0d] got %h want %h", i, loads_q[bl+i], list[i]); end
        end
        total = 0;
        for (int i = 0; i < 10; i++) total += int_of_fp(list[i]);
        if (rsum_q.size() > br) begin
            n_cmp++; if (rsum_q[br] !== fp_of_int(total)) begin n_err++; $display("FAIL sim_sum got %h want %h", rsum_q[br], fp_of_int(total)); end
        end
        n_cmp++; if (dbl_cnt !== 0) begin n_err++; $display("FAIL back_to_back_load got %0d want 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_sticky();
        test_random();
        test_reset_mid();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
